watchdog_window_multi: RTL and testbench
========================================

// Module: watchdog_window_multi
// PURPOSE
//  Multi-channel windowed watchdog. Each of N_CH supervised agents owns an independent kick channel.
//  A missed kick or an early kick drives that channel to fail-safe. If the agent does not recover,
//  a shared sequencer asserts a timed hardware reset and records which channel(s) caused it.
//  Sits between the CPU/agent cluster and the board reset/fail-safe logic.
// PARAMETERS
//  N_CH       4   number of independent watchdog channels (1..32)
//  CNT_W      32  width of every period input and internal counter
//  WINDOW_EN  1   1: early-kick detection active; 0: any kick accepted (window check bypassed)
// PORTS
//  i_clk          in   1       single clock; all logic on posedge
//  i_rst          in   1       synchronous, active-high reset
//  i_ch_en        in   N_CH    per-channel enable; 0 = channel idle, outputs cleared
//  i_clrwdt       in   N_CH    per-channel kick, sampled each cycle (level, one kick per high cycle)
//  i_wait_period  in   CNT_W   cycles allowed between kicks (shared by all channels)
//  i_window_open  in   CNT_W   kick legal only while channel counter <= this value
//  i_esc_period   in   CNT_W   cycles in fail-safe before hardware reset is requested
//  i_rst_period   in   CNT_W   length of o_hardware_rst pulse (0 treated as 1)
//  o_fail_safe    out  N_CH    per-channel fail-safe flag, registered
//  o_early_kick   out  N_CH    1-cycle pulse: kick rejected because it arrived before the window
//  o_hardware_rst out  1       registered hardware reset, shared
//  o_rst_cause    out  N_CH    sticky mask of channels that triggered the last hardware reset
// BEHAVIOUR
//  Reset: all channels IDLE, counters 0, every output 0; o_rst_cause cleared only by i_rst.
//  Channel FSM: IDLE -> RUN -> FAILSAFE -> ESCALATED; sequencer FSM: SEQ_IDLE -> SEQ_RST.
//  IDLE: i_ch_en=1 -> RUN with cnt=i_wait_period.
//  RUN: cnt decrements by 1 each cycle, saturating at 0.
//   - Legal kick (WINDOW_EN=0, or cnt<=i_window_open): reload cnt=i_wait_period.
//   - Early kick (WINDOW_EN=1 and cnt>i_window_open): o_early_kick pulse; -> FAILSAFE.
//   - cnt==0 and no kick: -> FAILSAFE.
//   Timing: kick at edge t gives fail-safe at edge t+P+1 (P=i_wait_period); o_fail_safe visible after that edge.
//  FAILSAFE: o_fail_safe=1; cnt loaded with i_esc_period on entry, decrements each cycle.
//   - Legal kick (window not checked here): -> RUN, o_fail_safe=0, cnt=i_wait_period (agent recovered).
//   - cnt==0 and no kick: -> ESCALATED; raise escalation request.
//  ESCALATED: o_fail_safe stays 1; channel inputs ignored until the sequencer releases.
//  Sequencer: any escalation request in SEQ_IDLE -> SEQ_RST next edge.
//   - Load rcnt=max(i_rst_period,1); o_rst_cause <= mask of requesting channels.
//   - In SEQ_RST: o_hardware_rst=1 for exactly rcnt cycles; all channels frozen; kicks ignored.
//   - On the last SEQ_RST cycle: o_hardware_rst=0 next edge; every enabled channel -> RUN, cnt=i_wait_period,
//     o_fail_safe=0; disabled channels -> IDLE.
//  Simultaneous events:
//   - Kick and cnt==0 in the same cycle: kick wins (0 is always inside the window).
//   - Several channels escalate in the same cycle: one reset pulse; all their bits set in o_rst_cause.
//   - An escalation arriving during SEQ_RST is ignored (all channels are frozen).
//   - i_ch_en=0 wins in any channel state except during SEQ_RST.
//     Channel -> IDLE, o_fail_safe bit=0; o_rst_cause bit kept.
//   - Period inputs are sampled only at load points; mid-count changes take effect at the next reload.
//   - i_wait_period=0: fail-safe one cycle after entering RUN unless a kick arrives in that cycle.
//   - i_esc_period=0: escalation one cycle after entering FAILSAFE.
//   - i_rst asserted mid-sequence: everything returns to reset values on that edge; o_hardware_rst drops.
// STRUCTURE
//  Package watchdog_pkg contains:
//   - channel state encoding (WD_IDLE, WD_RUN, WD_FAILSAFE, WD_ESC);
//   - sequencer encoding (SEQ_IDLE, SEQ_RST).
//  Sub-module watchdog_channel: one channel FSM and counter.
//   - Inputs: clk, rst, en, kick, periods, freeze, release.
//   - Outputs: fail_safe, early_kick, esc_req.
//   - Instantiated N_CH times by a generate loop.
//  Top level contains the sequencer, the reset counter and the cause latch.
// TESTING
//  1. N_CH=4, wait=10, window=10, ch0 kicked every 8 cycles for 200 cycles
//     -> o_fail_safe=0, o_hardware_rst=0 throughout.
//  2. ch1 enabled, no kicks, wait=5, esc=3, rst=4
//     -> o_fail_safe[1] rises 6 cycles after enable; o_hardware_rst high 4 cycles after FAILSAFE+ESC;
//        o_rst_cause=4'b0010; ch1 back in RUN after the pulse.
//  3. wait=20, window=5, kick ch2 when cnt=12 -> o_early_kick[2] 1-cycle pulse, o_fail_safe[2]=1 next edge;
//     repeat with WINDOW_EN=0 -> kick accepted.
//  4. ch3 in FAILSAFE with esc=10, kick after 4 cycles -> o_fail_safe[3]=0, no hardware reset.
//  5. ch0 and ch2 escalate on the same edge -> single pulse, o_rst_cause=4'b0101;
//     ch1 escalating during the pulse adds no second pulse.
//  6. i_rst asserted in cycle 2 of a rst=8 pulse -> o_hardware_rst=0, o_rst_cause=0, all channels IDLE next edge.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared encodings for the multi-channel windowed watchdog.
package watchdog_pkg;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_RUN,
    WD_FAILSAFE,
    WD_ESC
  } wd_state_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RST
  } seq_state_t;

endpackage

// File: rtl/watchdog_channel.sv
// One supervised watchdog channel: kick window check, fail-safe and escalation.
module watchdog_channel
  import watchdog_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic [CNT_W-1:0] wait_period,
  input  logic [CNT_W-1:0] window_open,
  input  logic [CNT_W-1:0] esc_period,
  input  logic             freeze,
  input  logic             release_now,
  output logic             fail_safe,
  output logic             early_kick,
  output logic             esc_req
);

  wd_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fs_q, fs_n;
  logic             in_window;

  // 0 is always inside the window, so a kick on the expiry cycle is legal
  assign in_window = !WINDOW_EN || (cnt <= window_open);

  // State, counter and fail-safe flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WD_IDLE;
      cnt   <= '0;
      fs_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      fs_q  <= fs_n;
    end
  end

  // Next-state logic; the reset sequencer freeze outranks the channel enable
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    fs_n       = fs_q;
    early_kick = 1'b0;
    if (freeze) begin
      if (release_now) begin
        state_n = en ? WD_RUN : WD_IDLE;
        cnt_n   = en ? wait_period : '0;
        fs_n    = 1'b0;
      end
    end else if (!en) begin
      state_n = WD_IDLE;
      cnt_n   = '0;
      fs_n    = 1'b0;
    end else begin
      case (state)
        WD_IDLE: begin
          state_n = WD_RUN;
          cnt_n   = wait_period;
        end
        WD_RUN: begin
          if (kick && in_window) begin
            cnt_n = wait_period;
          end else if (kick) begin
            early_kick = 1'b1;
            state_n    = WD_FAILSAFE;
            cnt_n      = esc_period;
            fs_n       = 1'b1;
          end else if (cnt == '0) begin
            state_n = WD_FAILSAFE;
            cnt_n   = esc_period;
            fs_n    = 1'b1;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        WD_FAILSAFE: begin
          if (kick) begin
            state_n = WD_RUN;
            cnt_n   = wait_period;
            fs_n    = 1'b0;
          end else if (cnt == '0) begin
            state_n = WD_ESC;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fail_safe = fs_q;
  assign esc_req   = (state == WD_ESC);

endmodule

// File: rtl/watchdog_window_multi.sv
// Multi-channel windowed watchdog with a shared hardware-reset sequencer.
module watchdog_window_multi
  import watchdog_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 32,
  parameter int WINDOW_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_CH-1:0]  i_ch_en,
  input  logic [N_CH-1:0]  i_clrwdt,
  input  logic [CNT_W-1:0] i_wait_period,
  input  logic [CNT_W-1:0] i_window_open,
  input  logic [CNT_W-1:0] i_esc_period,
  input  logic [CNT_W-1:0] i_rst_period,
  output logic [N_CH-1:0]  o_fail_safe,
  output logic [N_CH-1:0]  o_early_kick,
  output logic             o_hardware_rst,
  output logic [N_CH-1:0]  o_rst_cause
);

  seq_state_t       seq, seq_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic             hw_q, hw_n;
  logic [N_CH-1:0]  cause_q, cause_n;
  logic [N_CH-1:0]  esc_req;
  logic             freeze;
  logic             release_now;

  assign freeze      = (seq == SEQ_RST);
  assign release_now = freeze && (rcnt == CNT_W'(1));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    watchdog_channel #(
      .CNT_W     (CNT_W),
      .WINDOW_EN (WINDOW_EN != 0)
    ) u_ch (
      .clk         (i_clk),
      .rst         (i_rst),
      .en          (i_ch_en[g]),
      .kick        (i_clrwdt[g]),
      .wait_period (i_wait_period),
      .window_open (i_window_open),
      .esc_period  (i_esc_period),
      .freeze      (freeze),
      .release_now (release_now),
      .fail_safe   (o_fail_safe[g]),
      .early_kick  (o_early_kick[g]),
      .esc_req     (esc_req[g])
    );
  end

  // Sequencer state, reset-length counter, reset output and cause latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq     <= SEQ_IDLE;
      rcnt    <= '0;
      hw_q    <= 1'b0;
      cause_q <= '0;
    end else begin
      seq     <= seq_n;
      rcnt    <= rcnt_n;
      hw_q    <= hw_n;
      cause_q <= cause_n;
    end
  end

  // Requests are only accepted while idle; a zero reset length becomes one cycle
  always_comb begin
    seq_n   = seq;
    rcnt_n  = rcnt;
    hw_n    = hw_q;
    cause_n = cause_q;
    case (seq)
      SEQ_IDLE: begin
        if (|esc_req) begin
          seq_n   = SEQ_RST;
          rcnt_n  = (i_rst_period == '0) ? CNT_W'(1) : i_rst_period;
          hw_n    = 1'b1;
          cause_n = esc_req;
        end
      end
      SEQ_RST: begin
        if (rcnt == CNT_W'(1)) begin
          seq_n  = SEQ_IDLE;
          rcnt_n = '0;
          hw_n   = 1'b0;
        end else begin
          rcnt_n = rcnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_hardware_rst = hw_q;
  assign o_rst_cause    = cause_q;

endmodule

// File: tb/tb_watchdog_window_multi.sv
// Self-checking bench: a windowed and a window-bypassed instance share stimulus;
// a timestamp-based reference model predicts every output each cycle.
module tb_watchdog_window_multi;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_ch_en = '0;
  logic [3:0]  i_clrwdt = '0;
  logic [31:0] wp = '0, wo = '0, ep = '0, rp = '0;

  logic [3:0] fs_a, ek_a, rc_a, fs_b, ek_b, rc_b;
  logic       hw_a, hw_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: per instance w (0 windowed, 1 bypassed), per channel
  int m_act [2][4];
  int m_fs  [2][4];
  int m_esc [2][4];
  int m_tl  [2][4];
  int m_vl  [2][4];
  int m_seq [2];
  int m_send[2];
  logic [3:0] m_cause[2];

  always #5 i_clk = ~i_clk;

  watchdog_window_multi #(.N_CH(4), .CNT_W(32), .WINDOW_EN(1)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_ch_en(i_ch_en), .i_clrwdt(i_clrwdt),
    .i_wait_period(wp), .i_window_open(wo), .i_esc_period(ep), .i_rst_period(rp),
    .o_fail_safe(fs_a), .o_early_kick(ek_a), .o_hardware_rst(hw_a), .o_rst_cause(rc_a));

  watchdog_window_multi #(.N_CH(4), .CNT_W(32), .WINDOW_EN(0)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_ch_en(i_ch_en), .i_clrwdt(i_clrwdt),
    .i_wait_period(wp), .i_window_open(wo), .i_esc_period(ep), .i_rst_period(rp),
    .o_fail_safe(fs_b), .o_early_kick(ek_b), .o_hardware_rst(hw_b), .o_rst_cause(rc_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // remaining count: loaded value minus elapsed cycles, never below zero
  function automatic int mcnt(input int w, input int c);
    int r;
    r = m_vl[w][c] - (cyc - m_tl[w][c]);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic pred_early(input int w, input int c);
    return (w == 0) && (m_seq[w] == 0) && i_ch_en[c] && (m_act[w][c] != 0) &&
           (m_fs[w][c] == 0) && (m_esc[w][c] == 0) && i_clrwdt[c] && (mcnt(w, c) > int'(wo));
  endfunction

  function automatic logic [3:0] pred_fs(input int w);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (m_fs[w][c] != 0);
    return v;
  endfunction

  task automatic model_edge();
    int newc;
    newc = cyc + 1;
    for (int w = 0; w < 2; w++) begin
      if (i_rst) begin
        for (int c = 0; c < 4; c++) begin
          m_act[w][c] = 0; m_fs[w][c] = 0; m_esc[w][c] = 0; m_tl[w][c] = newc; m_vl[w][c] = 0;
        end
        m_seq[w] = 0; m_send[w] = 0; m_cause[w] = '0;
      end else begin
        int seq_was, rel, cnt, legal;
        logic [3:0] reqs;
        seq_was = m_seq[w];
        rel = (seq_was != 0) && (newc == m_send[w]);
        for (int c = 0; c < 4; c++) reqs[c] = (m_esc[w][c] != 0);
        for (int c = 0; c < 4; c++) begin
          if (seq_was != 0) begin
            if (rel != 0) begin
              m_act[w][c] = i_ch_en[c]; m_fs[w][c] = 0; m_esc[w][c] = 0;
              m_tl[w][c] = newc; m_vl[w][c] = i_ch_en[c] ? int'(wp) : 0;
            end
          end else if (!i_ch_en[c]) begin
            m_act[w][c] = 0; m_fs[w][c] = 0; m_esc[w][c] = 0;
          end else if (m_act[w][c] == 0) begin
            m_act[w][c] = 1; m_tl[w][c] = newc; m_vl[w][c] = int'(wp);
          end else if (m_esc[w][c] == 0) begin
            cnt = mcnt(w, c);
            legal = (m_fs[w][c] != 0) || (w == 1) || (cnt <= int'(wo));
            if (i_clrwdt[c] && legal != 0) begin
              m_fs[w][c] = 0; m_tl[w][c] = newc; m_vl[w][c] = int'(wp);
            end else if (i_clrwdt[c]) begin
              m_fs[w][c] = 1; m_tl[w][c] = newc; m_vl[w][c] = int'(ep);
            end else if (cnt == 0) begin
              if (m_fs[w][c] != 0) m_esc[w][c] = 1;
              else begin m_fs[w][c] = 1; m_tl[w][c] = newc; m_vl[w][c] = int'(ep); end
            end
          end
        end
        if (seq_was != 0) begin
          if (rel != 0) m_seq[w] = 0;
        end else if (reqs != 0) begin
          m_seq[w] = 1;
          m_send[w] = newc + ((rp == 0) ? 1 : int'(rp));
          m_cause[w] = reqs;
        end
      end
    end
    cyc = newc;
  endtask

  task automatic step(input logic [3:0] en, input logic [3:0] kick);
    @(negedge i_clk);
    i_ch_en = en;
    i_clrwdt = kick;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("early_a[%0d]@%0d", c, cyc), 32'(ek_a[c]), 32'(pred_early(0, c)));
      chk($sformatf("early_b[%0d]@%0d", c, cyc), 32'(ek_b[c]), 32'(pred_early(1, c)));
    end
    model_edge();
    @(posedge i_clk);
    #1;
    chk($sformatf("fs_a@%0d", cyc), 32'(fs_a), 32'(pred_fs(0)));
    chk($sformatf("fs_b@%0d", cyc), 32'(fs_b), 32'(pred_fs(1)));
    chk($sformatf("hw_a@%0d", cyc), 32'(hw_a), 32'(m_seq[0]));
    chk($sformatf("hw_b@%0d", cyc), 32'(hw_b), 32'(m_seq[1]));
    chk($sformatf("cause_a@%0d", cyc), 32'(rc_a), 32'(m_cause[0]));
    chk($sformatf("cause_b@%0d", cyc), 32'(rc_b), 32'(m_cause[1]));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    i_rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("reset_fs", 32'(fs_a), 32'h0);
    chk("reset_hw", 32'(hw_a), 32'h0);
    chk("reset_cause", 32'(rc_a), 32'h0);

    // steady kicking of ch0 inside the window
    wp = 10; wo = 10; ep = 5; rp = 3;
    for (int i = 0; i < 200; i++) step(4'b0001, (i % 8 == 7) ? 4'b0001 : 4'b0000);
    chk("t1_fs", 32'(fs_a), 32'h0);
    chk("t1_hw", 32'(hw_a), 32'h0);

    // unkicked ch1: fail-safe, escalation, reset pulse, back to run
    do_reset();
    wp = 5; ep = 3; rp = 4;
    for (int i = 0; i < 21; i++) step(4'b0010, 4'b0000);
    chk("t2_cause", 32'(rc_a), 32'h2);
    chk("t2_fs", 32'(fs_a), 32'h0);

    // early kick on ch2 at cnt=12 with window=5
    do_reset();
    wp = 20; wo = 5; ep = 10; rp = 2;
    for (int i = 0; i < 9; i++) step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    chk("t3_fs_windowed", 32'(fs_a[2]), 32'h1);
    chk("t3_fs_bypassed", 32'(fs_b[2]), 32'h0);
    for (int i = 0; i < 5; i++) step(4'b0100, 4'b0000);

    // recovery from fail-safe on ch3
    do_reset();
    wp = 3; wo = 3; ep = 10; rp = 2;
    step(4'b1000, 4'b0000);
    for (int i = 0; i < 20 && !fs_a[3]; i++) step(4'b1000, 4'b0000);
    chk("t4_fs_seen", 32'(fs_a[3]), 32'h1);
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b0000);
    step(4'b1000, 4'b1000);
    chk("t4_recovered", 32'(fs_a[3]), 32'h0);
    chk("t4_no_hw", 32'(hw_a), 32'h0);

    // simultaneous escalation of ch0/ch2; ch1 would escalate during the pulse
    do_reset();
    wp = 4; wo = 4; ep = 2; rp = 6;
    step(4'b0101, 4'b0000);
    step(4'b0101, 4'b0000);
    for (int i = 0; i < 14; i++) step(4'b0111, 4'b0000);
    chk("t5_cause", 32'(rc_a), 32'h5);

    // synchronous reset in the middle of a long pulse
    do_reset();
    wp = 2; ep = 1; rp = 8;
    for (int i = 0; i < 40 && !hw_a; i++) step(4'b0001, 4'b0000);
    chk("t6_pulse_seen", 32'(hw_a), 32'h1);
    step(4'b0001, 4'b0000);
    i_rst = 1'b1;
    step(4'b0001, 4'b0000);
    i_rst = 1'b0;
    chk("t6_hw", 32'(hw_a), 32'h0);
    chk("t6_cause", 32'(rc_a), 32'h0);
    chk("t6_fs", 32'(fs_a), 32'h0);

    // randomized traffic including zero periods and occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] en, kick;
      if (i % 50 == 0) begin
        wp = $urandom_range(0, 12);
        wo = $urandom_range(0, 12);
        ep = $urandom_range(0, 6);
        rp = $urandom_range(0, 5);
      end
      i_rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < 4; c++) begin
        en[c]   = ($urandom_range(0, 15) != 0);
        kick[c] = !i_rst && ($urandom_range(0, 5) == 0);
      end
      step(en, kick);
    end
    i_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
